// File: rtl/dco_fll_ctrl.sv
// Frequency-locked-loop controller for the on-chip DCO: SAR search for the
// control code, then +/-1 tracking against an edge count per reference window.
module dco_fll_ctrl #(
    parameter int CODE_W    = 8,
    parameter int CNT_W     = 12,
    parameter int WIN_LEN   = 1024,
    parameter int SETTLE    = 16,
    parameter int LOCK_TOL  = 2,
    parameter int LOCK_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic [CNT_W-1:0]  target,
    input  logic              dco_in,
    output logic [CODE_W-1:0] dco_code,
    output logic              busy,
    output logic              locked,
    output logic [CNT_W-1:0]  meas_count,
    output logic              meas_valid,
    output logic              err
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SAR_MEAS   = 3'd1,
        ST_SAR_DECIDE = 3'd2,
        ST_TRACK_MEAS = 3'd3,
        ST_TRACK_ADJ  = 3'd4
    } state_e;

    localparam int PH_W   = $clog2(SETTLE + WIN_LEN);
    localparam int IDX_W  = $clog2(CODE_W);
    localparam int HOLD_W = $clog2(LOCK_HOLD + 1);

    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(SETTLE + WIN_LEN - 1);
    localparam logic [PH_W-1:0]   PH_SETTLE = PH_W'(SETTLE);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CODE_W-1:0] CODE_MAX  = {CODE_W{1'b1}};
    localparam logic [CODE_W-1:0] CODE_MIN  = {CODE_W{1'b0}};
    localparam logic [CODE_W-1:0] CODE_MID  = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LOCK_HOLD);
    localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(LOCK_TOL);

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                locked_q, locked_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    meas_count_q, meas_count_d;
    logic                meas_valid_q, meas_valid_d;
    logic                busy_q, busy_d;
    logic [2:0]          sync_q;

    logic                edge_s;
    logic [CNT_W-1:0]    edge_sum_s;
    logic signed [CNT_W:0] diff_s;
    logic                in_tol_s;

    // sync_q[1:0] is the metastability chain; sync_q[2] is the previous sample for edge detect
    assign edge_s     = sync_q[1] & ~sync_q[2];
    assign edge_sum_s = (edge_cnt_q == CNT_MAX) ? CNT_MAX : (edge_cnt_q + CNT_W'(edge_s));
    assign diff_s     = $signed({1'b0, meas_count_q}) - $signed({1'b0, target});
    assign in_tol_s   = (diff_s <= TOL_S) && (diff_s >= -TOL_S);

    // Synchronize the asynchronous DCO output into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], dco_in};
        end
    end

    // Next-state logic: ena has priority over start, start over normal sequencing
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        idx_d        = idx_q;
        ph_d         = ph_q;
        edge_cnt_d   = edge_cnt_q;
        hold_d       = hold_q;
        locked_d     = locked_q;
        err_d        = err_q;
        meas_count_d = meas_count_q;
        meas_valid_d = 1'b0;

        if (!ena) begin
            state_d    = ST_IDLE;
            locked_d   = 1'b0;
            hold_d     = {HOLD_W{1'b0}};
            ph_d       = {PH_W{1'b0}};
            edge_cnt_d = {CNT_W{1'b0}};
        end else if (start) begin
            state_d    = ST_SAR_MEAS;
            code_d     = CODE_MID;
            idx_d      = IDX_W'(CODE_W - 1);
            err_d      = 1'b0;
            locked_d   = 1'b0;
            hold_d     = {HOLD_W{1'b0}};
            ph_d       = {PH_W{1'b0}};
            edge_cnt_d = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ph_d       = {PH_W{1'b0}};
                    edge_cnt_d = {CNT_W{1'b0}};
                end
                ST_SAR_MEAS, ST_TRACK_MEAS: begin
                    if (ph_q == PH_LAST) begin
                        meas_count_d = edge_sum_s;
                        meas_valid_d = 1'b1;
                        edge_cnt_d   = {CNT_W{1'b0}};
                        ph_d         = {PH_W{1'b0}};
                        state_d      = (state_q == ST_SAR_MEAS) ? ST_SAR_DECIDE : ST_TRACK_ADJ;
                    end else begin
                        ph_d       = ph_q + PH_W'(1);
                        edge_cnt_d = (ph_q >= PH_SETTLE) ? edge_sum_s : {CNT_W{1'b0}};
                    end
                end
                ST_SAR_DECIDE: begin
                    code_d[idx_q] = (meas_count_q > target) ? 1'b0 : code_q[idx_q];
                    if (idx_q != {IDX_W{1'b0}}) begin
                        code_d[idx_q - IDX_W'(1)] = 1'b1;
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = ST_SAR_MEAS;
                    end else begin
                        state_d = ST_TRACK_MEAS;
                    end
                end
                ST_TRACK_ADJ: begin
                    state_d = ST_TRACK_MEAS;
                    if (in_tol_s) begin
                        hold_d   = (hold_q == HOLD_MAX) ? hold_q : (hold_q + HOLD_W'(1));
                        locked_d = (hold_q >= HOLD_W'(LOCK_HOLD - 1));
                    end else if (diff_s > $signed({(CNT_W+1){1'b0}})) begin
                        hold_d   = {HOLD_W{1'b0}};
                        locked_d = 1'b0;
                        if (code_q == CODE_MIN) begin
                            err_d = 1'b1;
                        end else begin
                            code_d = code_q - CODE_W'(1);
                        end
                    end else begin
                        hold_d   = {HOLD_W{1'b0}};
                        locked_d = 1'b0;
                        if (code_q == CODE_MAX) begin
                            err_d = 1'b1;
                        end else begin
                            code_d = code_q + CODE_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Controller state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            code_q       <= {CODE_W{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            ph_q         <= {PH_W{1'b0}};
            edge_cnt_q   <= {CNT_W{1'b0}};
            hold_q       <= {HOLD_W{1'b0}};
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            meas_count_q <= {CNT_W{1'b0}};
            meas_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            idx_q        <= idx_d;
            ph_q         <= ph_d;
            edge_cnt_q   <= edge_cnt_d;
            hold_q       <= hold_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            meas_count_q <= meas_count_d;
            meas_valid_q <= meas_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign dco_code   = code_q;
    assign busy       = busy_q;
    assign locked     = locked_q;
    assign meas_count = meas_count_q;
    assign meas_valid = meas_valid_q;
    assign err        = err_q;

endmodule
